fifo_uart_tx: RTL

Drain stage on the read side of the team's byte FIFO. Whenever the FIFO is non-empty and transmission is enabled, it pops one word, frames it as an asynchronous serial character, and shifts it out on a single line. Frame format is start bit, data LSB first, optional parity, one stop bit. The block supplies the FIFO's read-enable and consumes its read-data and empty flag.

---
 rtl/fifo_uart_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// Read-side drain of the byte FIFO: pops one word at a time and sends it as an
// async serial frame (start, data LSB first, optional even parity, one stop).
// Optional parity bit is built when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             tx_enable,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd5
    } state_t;
`endif

    state_t             state, state_next;
    logic [BAUD_W-1:0]  baud_cnt, baud_next;
    logic [BIT_W-1:0]   bit_idx, bit_next;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic               tx_next, busy_next, done_next;
    logic               baud_last;
    logic               pop;

    // Pop request is combinational so the FIFO presents data during LOAD.
    assign pop        = rst_n && (state == ST_IDLE) && tx_enable && !fifo_empty;
    assign fifo_rd_en = pop;
    assign baud_last  = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= bit_next;
            shift_reg <= shift_next;
            tx        <= tx_next;
            busy      <= busy_next;
            tx_done   <= done_next;
        end
    end

    // Next-state and counters; outputs are derived from the next values so
    // they can be registered without adding a cycle of latency.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        done_next  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pop) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                shift_next = fifo_rd_data;
                baud_next  = '0;
                state_next = ST_START;
            end
            ST_START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = ST_DATA;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_idx == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_next = bit_idx + BIT_W'(1);
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    baud_next  = '0;
                    state_next = ST_STOP;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_last) begin
                    baud_next  = '0;
                    state_next = ST_IDLE;
                end else begin
                    baud_next = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                baud_next  = '0;
            end
        endcase

        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[bit_next];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx_next = ^shift_next;
`endif
            default:   tx_next = 1'b1;
        endcase

        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_STOP) && (baud_next == BAUD_LAST);
    end

endmodule
